// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package tx_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Largest supported number of requesters.
    localparam int MAX_REQ = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int GRANT_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: finds the first set bit of
// req starting at position ptr and wrapping modulo NUM_REQ.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GW      = GRANT_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic               any,
    output logic [GW-1:0]      idx
);

    // Walk the requesters in priority order from ptr, keep the first hit.
    always_comb begin
        int j;
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = GW'(j);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers. A grant latches the winner's byte, raises tx_send until the
// transmitter reports busy, acknowledges the requester, then waits for the
// transmitter to go idle before arbitrating again. If busy never rises the
// grant is abandoned and a sticky error is raised.
//
// Handshakes: a requester holds req_valid[i] with a stable byte until it
// sees the one-cycle req_ack[i]; tx_send stays high with tx_din stable
// until tx_busy is sampled high, which is the moment the byte is committed.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int GW           = GRANT_W(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_send,
    output logic [7:0]           tx_din,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 active,
    output logic                 err,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_send_q, tx_send_d;
    logic [7:0]         tx_din_q, tx_din_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               active_q, active_d;
    logic               err_q, err_d;

    logic               pick_any;
    logic [GW-1:0]      pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state and next-output logic for the grant/send/drain sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        tx_send_d = tx_send_q;
        tx_din_d  = tx_din_q;
        ack_d     = '0;
        active_d  = active_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d   = pick_idx;
                    tx_din_d  = req_data[8*pick_idx +: 8];
                    tx_send_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                    active_d  = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    // Byte committed: ack it and demote this requester.
                    tx_send_d = 1'b0;
                    ack_d     = NUM_REQ'(1) << grant_q;
                    ptr_d     = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d   = DRAIN;
                end else if (cnt_q == '0) begin
                    // Transmitter never answered; drop the grant, keep ptr.
                    tx_send_d = 1'b0;
                    err_d     = 1'b1;
                    active_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                active_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            tx_send_q <= 1'b0;
            tx_din_q  <= 8'h00;
            ack_q     <= '0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            tx_send_q <= tx_send_d;
            tx_din_q  <= tx_din_d;
            ack_q     <= ack_d;
            active_q  <= active_d;
            err_q     <= err_d;
        end
    end

    assign req_ack   = ack_q;
    assign tx_send   = tx_send_q;
    assign tx_din    = tx_din_q;
    assign grant_id  = grant_q;
    assign active    = active_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: a small serial transmitter model and line receiver,
// a cycle-level reference model of the arbitration rules, directed scenarios
// and a randomized traffic phase.
module tb_tx_arbiter;

    localparam int N        = 4;
    localparam int TO       = 16;
    localparam int BIT_CLKS = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ack;
    logic           tx_send;
    logic [7:0]     tx_din;
    logic [1:0]     grant_id;
    logic           active;
    logic           err;
    logic [1:0]     dbg_state;

    logic tx_busy_m = 1'b0;
    logic tx_out    = 1'b1;
    logic busy_stub = 1'b0;
    logic dut_busy;
    assign dut_busy = busy_stub ? 1'b0 : tx_busy_m;

    tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx_send   (tx_send),
        .tx_din    (tx_din),
        .tx_busy   (dut_busy),
        .grant_id  (grant_id),
        .active    (active),
        .err       (err),
        .dbg_state (dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    bit auto_exp = 1'b0;
    int rst_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transmitter model (8N1, BIT_CLKS per bit) ----------------
    logic [9:0] frame;
    int bit_idx = 0;
    int clk_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            tx_busy_m <= 1'b0;
            tx_out    <= 1'b1;
            bit_idx   <= 0;
            clk_cnt   <= 0;
        end else if (!tx_busy_m) begin
            if (tx_send && !busy_stub) begin
                frame     <= {1'b1, tx_din, 1'b0};
                tx_busy_m <= 1'b1;
                tx_out    <= 1'b0;
                bit_idx   <= 0;
                clk_cnt   <= 0;
            end
        end else if (clk_cnt == BIT_CLKS - 1) begin
            clk_cnt <= 0;
            if (bit_idx == 9) begin
                tx_busy_m <= 1'b0;
                tx_out    <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 1;
                tx_out  <= frame[bit_idx + 1];
            end
        end else begin
            clk_cnt <= clk_cnt + 1;
        end
    end

    always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

    // ---------------- line receiver + byte scoreboard ----------------
    always begin
        int start_rc;
        logic [7:0] rb;
        logic sb, pb;
        @(negedge tx_out);
        start_rc = rst_cnt;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 sb = tx_out;
        for (int b = 0; b < 8; b++) begin
            repeat (BIT_CLKS) @(posedge clk);
            #1 rb[b] = tx_out;
        end
        repeat (BIT_CLKS) @(posedge clk);
        #1 pb = tx_out;
        if (rst_cnt == start_rc) begin
            check("rx_start_bit", sb, 1'b0);
            check("rx_stop_bit", pb, 1'b1);
            check("rx_expected_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("rx_byte", rb, exp_q.pop_front());
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int         m_phase = 0;   // 0 waiting, 1 offering byte, 2 line busy
    int         m_since = 0;   // edges spent offering the current byte
    int         m_ptr   = 0;
    logic [1:0] m_gid   = '0;
    logic [7:0] m_din   = '0;
    logic       m_send  = 1'b0;
    logic       m_active = 1'b0;
    logic       m_err   = 1'b0;
    logic [N-1:0] m_ack = '0;
    logic [N-1:0]   mv;
    logic [8*N-1:0] md;
    logic           mb;
    logic           mr;
    bit             found;

    always begin
        @(posedge clk);
        mv = req_valid;
        md = req_data;
        mb = dut_busy;
        mr = rst;
        m_ack = '0;
        if (mr) begin
            m_phase = 0; m_since = 0; m_ptr = 0; m_gid = '0; m_din = '0;
            m_send = 1'b0; m_active = 1'b0; m_err = 1'b0;
        end else if (m_phase == 0) begin
            if (mv != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && mv[j]) begin
                        found = 1'b1;
                        m_gid = 2'(j);
                        m_din = md[8*j +: 8];
                    end
                end
                m_send = 1'b1; m_since = 0; m_active = 1'b1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_since++;
            if (mb) begin
                m_send = 1'b0;
                m_ack  = N'(1) << m_gid;
                m_ptr  = (int'(m_gid) + 1) % N;
                m_phase = 2;
                if (auto_exp) exp_q.push_back(m_din);
            end else if (m_since == TO) begin
                m_send = 1'b0; m_err = 1'b1; m_active = 1'b0; m_phase = 0;
            end
        end else begin
            if (!mb) begin
                m_active = 1'b0; m_phase = 0;
            end
        end
        #1;
        check("cyc_tx_send", tx_send, m_send);
        check("cyc_tx_din", tx_din, m_din);
        check("cyc_req_ack", req_ack, m_ack);
        check("cyc_grant_id", grant_id, m_gid);
        check("cyc_active", active, m_active);
        check("cyc_err", err, m_err);
    end

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic wait_drained(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || active) && t < budget) begin
            if (req_ack != '0) req_valid = req_valid & ~req_ack;
            @(negedge clk);
            t++;
        end
        check(name, (exp_q.size() == 0 && !active), 1);
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        int acks;
        int t;
        int hc;
        int ack_order[8];
        int exp_order[8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_din", tx_din, 8'h00);
        check("rst_req_ack", req_ack, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_active", active, 0);
        check("rst_err", err, 0);
        check("rst_tx_out", tx_out, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single requester
        req_data[23:16] = 8'h5A;
        req_valid = 4'b0100;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        check("single_grant_id", grant_id, 2);
        check("single_tx_din", tx_din, 8'h5A);
        check("single_tx_send", tx_send, 1);
        acks = 0;
        t = 0;
        while (t < 200 && !(exp_q.size() == 0 && !active)) begin
            if (req_ack != '0) begin
                acks++;
                check("single_ack_vec", req_ack, 4'b0100);
                req_valid = '0;
            end
            @(negedge clk);
            t++;
        end
        check("single_ack_count", acks, 1);
        check("single_drained", exp_q.size(), 0);

        // Full contention from a fresh pointer
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'h10); exp_q.push_back(8'h21);
            exp_q.push_back(8'h32); exp_q.push_back(8'h43);
        end
        req_valid = 4'hF;
        acks = 0;
        t = 0;
        while (t < 2000 && !(acks == 8 && exp_q.size() == 0 && !active)) begin
            if (req_ack != '0) begin
                for (int i = 0; i < N; i++)
                    if (req_ack[i] && acks < 8) ack_order[acks] = i;
                acks++;
                if (acks >= 8) req_valid = '0;
            end
            @(negedge clk);
            t++;
        end
        check("cont_ack_count", acks, 8);
        for (int i = 0; i < 8; i++) check("cont_ack_order", ack_order[i], exp_order[i]);
        check("cont_drained", exp_q.size(), 0);

        // Data change and valid drop after grant
        req_data[15:8] = 8'hA5;
        req_valid = 4'b0010;
        exp_q.push_back(8'hA5);
        t = 0;
        while (!tx_send && t < 20) begin @(negedge clk); t++; end
        check("chg_send_seen", tx_send, 1);
        req_data[15:8] = 8'hFF;
        req_valid[1] = 1'b0;
        acks = 0;
        t = 0;
        while (t < 200 && !(exp_q.size() == 0 && !active)) begin
            if (req_ack != '0) begin
                acks++;
                check("chg_ack_vec", req_ack, 4'b0010);
            end
            @(negedge clk);
            t++;
        end
        check("chg_ack_count", acks, 1);
        check("chg_drained", exp_q.size(), 0);

        // Timeout with a transmitter that never goes busy
        busy_stub = 1'b1;
        req_data[7:0] = 8'h77;
        req_valid = 4'b0001;
        t = 0;
        while (!tx_send && t < 20) begin @(negedge clk); t++; end
        req_valid = '0;
        hc = 0;
        acks = 0;
        t = 0;
        while (tx_send && t < 40) begin
            hc++;
            if (req_ack != '0) acks++;
            @(negedge clk);
            t++;
        end
        check("to_send_cycles", hc, TO);
        check("to_err", err, 1);
        check("to_active", active, 0);
        check("to_state_idle", dbg_state, 0);
        check("to_no_ack", acks, 0);
        busy_stub = 1'b0;
        @(negedge clk);

        // Reset in the middle of a character
        req_data[23:16] = 8'h3C;
        req_valid = 4'b0100;
        t = 0;
        while (!tx_busy_m && t < 20) begin
            if (req_ack != '0) req_valid = '0;
            @(negedge clk);
            t++;
        end
        check("mid_busy_seen", tx_busy_m, 1);
        repeat (4 * BIT_CLKS) begin
            if (req_ack != '0) req_valid = '0;
            @(negedge clk);
        end
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
        end
        check("mid_tx_send", tx_send, 0);
        check("mid_active", active, 0);
        check("mid_tx_busy", tx_busy_m, 0);
        check("mid_tx_out", tx_out, 1);
        check("mid_err_cleared", err, 0);
        check("mid_no_ack", acks, 0);
        repeat (60) @(negedge clk);

        // Randomized traffic
        auto_exp = 1'b1;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 99) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        wait_drained("rand_drained", 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
